// File: rtl/result_slot_scheduler.sv
// Result slot scheduler: carves the result memory into NUM_SLOTS fixed-stride slots,
// allocates them round-robin to flagged packets, and tracks occupancy until host release.
module result_slot_scheduler #(
   parameter int unsigned NUM_SLOTS   = 5,
   parameter int unsigned SLOT_STRIDE = 1550,
   parameter int unsigned DATA_W      = 32
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 pkt_start,
   input  logic                 pkt_valid,
   input  logic [DATA_W-1:0]    pkt_data,
   input  logic                 pkt_end,
   input  logic [NUM_SLOTS-1:0] host_release,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [NUM_SLOTS-1:0] slot_full,
   output logic                 done,
   output logic [3:0]           done_slot,
   output logic [15:0]          done_len,
   output logic                 truncated,
   output logic                 overflow
);

   localparam logic [15:0] STRIDE16  = 16'(SLOT_STRIDE);
   localparam logic [31:0] STRIDE32  = 32'(SLOT_STRIDE);
   localparam logic [3:0]  LAST_SLOT = 4'(NUM_SLOTS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_e;

   state_e               state_q, state_d;
   logic [3:0]           wr_ptr_q, wr_ptr_d;
   logic [31:0]          base_q, base_d;
   logic [15:0]          count_q, count_d;
   logic                 trunc_q, trunc_d;
   logic [NUM_SLOTS-1:0] slot_full_q, slot_full_d;
   logic                 mem_we_q, mem_we_d;
   logic [31:0]          mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
   logic                 done_q, done_d;
   logic [3:0]           done_slot_q, done_slot_d;
   logic [15:0]          done_len_q, done_len_d;
   logic                 truncated_q, truncated_d;
   logic                 overflow_q, overflow_d;

   logic [NUM_SLOTS-1:0] ptr_onehot;
   logic                 slot_busy;
   logic [31:0]          new_base;
   logic                 room;
   logic                 commit;
   logic [15:0]          commit_len;
   logic                 commit_trunc;

   always_comb begin
      ptr_onehot   = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << wr_ptr_q;
      // Occupancy is judged on the registered value, so a same-cycle release never frees the slot for this start
      slot_busy    = |(slot_full_q & ptr_onehot);
      new_base     = 32'(wr_ptr_q) * STRIDE32;
      room         = count_q < STRIDE16;

      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      base_d       = base_q;
      count_d      = count_q;
      trunc_d      = trunc_q;
      slot_full_d  = slot_full_q & ~host_release;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      done_d       = 1'b0;
      done_slot_d  = done_slot_q;
      done_len_d   = done_len_q;
      truncated_d  = 1'b0;
      overflow_d   = 1'b0;
      commit       = 1'b0;
      commit_len   = '0;
      commit_trunc = 1'b0;

      case (state_q)
         IDLE: begin
            if (pkt_valid && pkt_start) begin
               if (!slot_busy) begin
                  base_d      = new_base;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = new_base;
                  mem_wdata_d = pkt_data;
                  if (pkt_end) begin
                     commit     = 1'b1;
                     commit_len = 16'd1;
                  end else begin
                     state_d = WRITE;
                     count_d = 16'd1;
                  end
               end else begin
                  overflow_d = 1'b1;
                  if (!pkt_end) state_d = DISCARD;
               end
            end
         end
         WRITE: begin
            if (pkt_valid) begin
               if (room) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = base_q + 32'(count_q);
                  mem_wdata_d = pkt_data;
                  count_d     = count_q + 16'd1;
               end else begin
                  trunc_d = 1'b1;
               end
               if (pkt_end) begin
                  commit       = 1'b1;
                  commit_len   = room ? count_q + 16'd1 : STRIDE16;
                  commit_trunc = trunc_q | ~room;
               end
            end
         end
         DISCARD: begin
            if (pkt_valid && pkt_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Set after the release mask so a release aimed at the committing slot is ignored
      if (commit) begin
         slot_full_d = slot_full_d | ptr_onehot;
         done_d      = 1'b1;
         done_slot_d = wr_ptr_q;
         done_len_d  = commit_len;
         truncated_d = commit_trunc;
         wr_ptr_d    = (wr_ptr_q == LAST_SLOT) ? 4'd0 : wr_ptr_q + 4'd1;
         count_d     = '0;
         trunc_d     = 1'b0;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         base_q      <= '0;
         count_q     <= '0;
         trunc_q     <= 1'b0;
         slot_full_q <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         done_slot_q <= '0;
         done_len_q  <= '0;
         truncated_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         base_q      <= base_d;
         count_q     <= count_d;
         trunc_q     <= trunc_d;
         slot_full_q <= slot_full_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         done_slot_q <= done_slot_d;
         done_len_q  <= done_len_d;
         truncated_q <= truncated_d;
         overflow_q  <= overflow_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign slot_full = slot_full_q;
   assign done      = done_q;
   assign done_slot = done_slot_q;
   assign done_len  = done_len_q;
   assign truncated = truncated_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_slot_scheduler.sv
// Bench for result_slot_scheduler: two builds (stride 1550 and stride 4) share one stimulus
// stream and are each compared every cycle against a packet-level model of slot allocation.
module tb_result_slot_scheduler;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        pkt_start = 1'b0, pkt_valid = 1'b0, pkt_end = 1'b0;
   logic [31:0] pkt_data = '0;
   logic [4:0]  host_release = '0;

   logic        a_we, b_we, a_done, b_done, a_tr, b_tr, a_ovf, b_ovf;
   logic [31:0] a_addr, b_addr, a_wd, b_wd;
   logic [4:0]  a_full, b_full;
   logic [3:0]  a_ds, b_ds;
   logic [15:0] a_dl, b_dl;

   result_slot_scheduler #(.NUM_SLOTS(5), .SLOT_STRIDE(1550), .DATA_W(32)) dut_a (
      .clk(clk), .n_rst(n_rst), .pkt_start(pkt_start), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
      .pkt_end(pkt_end), .host_release(host_release), .mem_we(a_we), .mem_addr(a_addr),
      .mem_wdata(a_wd), .slot_full(a_full), .done(a_done), .done_slot(a_ds), .done_len(a_dl),
      .truncated(a_tr), .overflow(a_ovf));

   result_slot_scheduler #(.NUM_SLOTS(5), .SLOT_STRIDE(4), .DATA_W(32)) dut_b (
      .clk(clk), .n_rst(n_rst), .pkt_start(pkt_start), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
      .pkt_end(pkt_end), .host_release(host_release), .mem_we(b_we), .mem_addr(b_addr),
      .mem_wdata(b_wd), .slot_full(b_full), .done(b_done), .done_slot(b_ds), .done_len(b_dl),
      .truncated(b_tr), .overflow(b_ovf));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Packet-level model, one entry per build
   int          stride [2] = '{1550, 4};
   bit          busy [2], disc [2];
   int          ptr [2], beats [2], base [2];
   logic [4:0]  occ [2];
   bit          e_we [2], e_done [2], e_trunc [2], e_ovf [2];
   logic [31:0] e_addr [2], e_wdata [2];
   int          e_slot [2], e_len [2];

   // Observed-event log used by the hand-computed checks
   int          n_done [2], n_ovf [2], n_we [2];
   int          l_slot [2], l_len [2], l_trunc [2];
   logic [31:0] l_waddr [2], l_wdata [2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         busy[i] = 0; disc[i] = 0; ptr[i] = 0; beats[i] = 0; base[i] = 0; occ[i] = '0;
         e_we[i] = 0; e_done[i] = 0; e_trunc[i] = 0; e_ovf[i] = 0;
         e_addr[i] = '0; e_wdata[i] = '0; e_slot[i] = 0; e_len[i] = 0;
      end
   endtask

   task automatic model_step(input int i);
      bit commit;
      int len;
      bit tr;
      commit = 0; len = 0; tr = 0;
      e_we[i] = 0; e_done[i] = 0; e_trunc[i] = 0; e_ovf[i] = 0;
      if (busy[i]) begin
         if (pkt_valid) begin
            if (beats[i] < stride[i]) begin
               e_we[i] = 1; e_addr[i] = 32'(base[i] + beats[i]); e_wdata[i] = pkt_data;
            end
            beats[i]++;
            if (pkt_end) begin
               commit = 1;
               len = (beats[i] < stride[i]) ? beats[i] : stride[i];
               tr = beats[i] > stride[i];
               busy[i] = 0;
            end
         end
      end else if (disc[i]) begin
         if (pkt_valid && pkt_end) disc[i] = 0;
      end else if (pkt_valid && pkt_start) begin
         if (occ[i][ptr[i]] == 1'b0) begin
            base[i] = ptr[i] * stride[i];
            e_we[i] = 1; e_addr[i] = 32'(base[i]); e_wdata[i] = pkt_data;
            if (pkt_end) begin
               commit = 1; len = 1;
            end else begin
               busy[i] = 1; beats[i] = 1;
            end
         end else begin
            e_ovf[i] = 1;
            if (!pkt_end) disc[i] = 1;
         end
      end
      occ[i] = occ[i] & ~host_release;
      if (commit) begin
         occ[i][ptr[i]] = 1'b1;
         e_done[i] = 1; e_slot[i] = ptr[i]; e_len[i] = len; e_trunc[i] = tr;
         ptr[i] = (ptr[i] + 1) % 5;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) model_reset();
         else begin
            model_step(0);
            model_step(1);
         end
      end
   end

   task automatic check_dut(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [4:0] full, input logic dn, input logic [3:0] ds,
                            input logic [15:0] dl, input logic tr, input logic ov);
      string s;
      s = (i == 0) ? "a" : "b";
      chk({s, ".mem_we"}, 32'(we), 32'(e_we[i]));
      chk({s, ".mem_addr"}, addr, e_addr[i]);
      if (e_we[i]) chk({s, ".mem_wdata"}, wd, e_wdata[i]);
      chk({s, ".slot_full"}, 32'(full), 32'(occ[i]));
      chk({s, ".done"}, 32'(dn), 32'(e_done[i]));
      chk({s, ".overflow"}, 32'(ov), 32'(e_ovf[i]));
      if (e_done[i]) begin
         chk({s, ".done_slot"}, 32'(ds), 32'(e_slot[i]));
         chk({s, ".done_len"}, 32'(dl), 32'(e_len[i]));
         chk({s, ".truncated"}, 32'(tr), 32'(e_trunc[i]));
      end
      if (dn) begin n_done[i]++; l_slot[i] = ds; l_len[i] = dl; l_trunc[i] = tr; end
      if (ov) n_ovf[i]++;
      if (we) begin n_we[i]++; l_waddr[i] = addr; l_wdata[i] = wd; end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check_dut(0, a_we, a_addr, a_wd, a_full, a_done, a_ds, a_dl, a_tr, a_ovf);
         check_dut(1, b_we, b_addr, b_wd, b_full, b_done, b_ds, b_dl, b_tr, b_ovf);
      end
   end

   task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d,
                        input logic [4:0] rel);
      @(negedge clk);
      pkt_valid = v; pkt_start = s; pkt_end = e; pkt_data = d; host_release = rel;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic send_pkt(input int len, input logic [31:0] d0, input bit rnd);
      logic [4:0] rel;
      for (int k = 0; k < len; k++) begin
         if (rnd) begin
            while ($urandom_range(3) == 0)
               drive(1'b0, 1'($urandom), 1'($urandom), $urandom, '0);
         end
         rel = (rnd && $urandom_range(5) == 0) ? 5'($urandom) : 5'b0;
         drive(1'b1, (k == 0) || (rnd && k > 0 && $urandom_range(7) == 0), k == len - 1,
               rnd ? $urandom : d0 + 32'(k), rel);
      end
   endtask

   int we0;

   initial begin
      for (int i = 0; i < 2; i++) begin
         n_done[i] = 0; n_ovf[i] = 0; n_we[i] = 0;
         l_slot[i] = 0; l_len[i] = 0; l_trunc[i] = 0; l_waddr[i] = '0; l_wdata[i] = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst.mem_we", 32'(a_we), 0);
      chk("rst.mem_addr", a_addr, 0);
      chk("rst.slot_full", 32'(a_full), 0);
      chk("rst.done", 32'(a_done), 0);
      chk("rst.overflow", 32'(a_ovf), 0);
      n_rst = 1'b1;
      idle(2);

      // Single 3-word packet
      send_pkt(3, 32'hA0, 0);
      idle(2);
      chk("p1.n_done", 32'(n_done[0]), 1);
      chk("p1.done_slot", 32'(l_slot[0]), 0);
      chk("p1.done_len", 32'(l_len[0]), 3);
      chk("p1.last_addr", l_waddr[0], 2);
      chk("p1.last_data", l_wdata[0], 32'hA2);
      chk("p1.slot_full", 32'(a_full), 5'b00001);

      // Fill remaining slots with 2-word packets
      for (int p = 0; p < 4; p++) begin
         send_pkt(2, 32'h100 * 32'(p), 0);
         idle(1);
      end
      idle(1);
      chk("fill.slot_full", 32'(a_full), 5'b11111);
      chk("fill.n_done", 32'(n_done[0]), 5);
      chk("fill.last_addr_a", l_waddr[0], 6201);
      chk("fill.last_addr_b", l_waddr[1], 17);

      // All full: overflow, packet swallowed
      we0 = n_we[0];
      send_pkt(3, 32'hBB, 0);
      idle(2);
      chk("ovf.count", 32'(n_ovf[0]), 1);
      chk("ovf.no_write", 32'(n_we[0]), 32'(we0));
      chk("ovf.slot_full", 32'(a_full), 5'b11111);

      drive(1'b0, 1'b0, 1'b0, '0, 5'b00001);
      idle(1);
      send_pkt(2, 32'hCC, 0);
      idle(2);
      chk("rel.done_slot", 32'(l_slot[0]), 0);
      chk("rel.last_addr", l_waddr[0], 1);

      drive(1'b0, 1'b0, 1'b0, '0, 5'b11111);
      idle(2);
      chk("relall.slot_full", 32'(a_full), 0);

      // Over-length packet: truncated in the stride-4 build only
      send_pkt(6, 32'hC0, 0);
      idle(2);
      chk("trunc.b_len", 32'(l_len[1]), 4);
      chk("trunc.b_flag", 32'(l_trunc[1]), 1);
      chk("trunc.b_last_addr", l_waddr[1], 7);
      chk("trunc.a_len", 32'(l_len[0]), 6);
      chk("trunc.a_flag", 32'(l_trunc[0]), 0);
      send_pkt(2, 32'hD0, 0);
      idle(2);
      chk("after_trunc.b_flag", 32'(l_trunc[1]), 0);
      chk("after_trunc.b_slot", 32'(l_slot[1]), 2);
      chk("after_trunc.b_last_addr", l_waddr[1], 9);

      // Single-beat packet followed immediately by another start
      drive(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, '0);
      @(posedge clk);
      #1;
      chk("single.done", 32'(a_done), 1);
      chk("single.wdata", a_wd, 32'hDEADBEEF);
      chk("single.addr", a_addr, 4650);
      chk("single.len", 32'(a_dl), 1);
      chk("single.slot", 32'(a_ds), 3);
      send_pkt(2, 32'hE0, 0);
      idle(2);
      chk("single.next_slot", 32'(l_slot[0]), 4);

      drive(1'b0, 1'b0, 1'b0, '0, 5'b11111);
      idle(1);

      // Randomized traffic with releases, gaps and spurious flags
      for (int p = 0; p < 250; p++) begin
         send_pkt(int'($urandom_range(8, 1)), '0, 1);
         if ($urandom_range(2) == 0) drive(1'b0, 1'b0, 1'b0, '0, 5'($urandom));
      end
      idle(2);

      // Reset mid-packet
      drive(1'b1, 1'b1, 1'b0, 32'h11, '0);
      drive(1'b1, 1'b0, 1'b0, 32'h12, '0);
      @(negedge clk);
      pkt_valid = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0; host_release = '0;
      n_rst = 1'b0;
      #1;
      chk("midrst.slot_full", 32'(a_full), 0);
      chk("midrst.mem_we", 32'(a_we), 0);
      chk("midrst.mem_addr", a_addr, 0);
      chk("midrst.done", 32'(a_done), 0);
      @(negedge clk);
      n_rst = 1'b1;
      idle(1);
      send_pkt(2, 32'hF0, 0);
      idle(2);
      chk("midrst.next_slot", 32'(l_slot[0]), 0);
      chk("midrst.next_addr", l_waddr[0], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/result_slot_scheduler.md
Name: result_slot_scheduler

Overview:
- Owns the output result memory: carves it into NUM_SLOTS fixed-stride slots.
- Allocates slots round-robin to flagged packets and streams packet words into the allocated slot.
- Reports completed slots to the host and frees them on host release.
- Sits between the match/filter stage and the output FIFO/memory write port. It supersedes the fixed rotating-address sequencer by adding occupancy tracking and overflow handling.

Parameters:
- NUM_SLOTS, 5: number of result slots; 2..16.
- SLOT_STRIDE, 1550: slot size in memory words; slot k base = k*SLOT_STRIDE.
- DATA_W, 32: packet data word width.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- pkt_start  in  1  first beat of a flagged packet; qualified by pkt_valid.
- pkt_valid  in  1  pkt_data valid this cycle.
- pkt_data  in  DATA_W  packet word.
- pkt_end  in  1  last beat; qualified by pkt_valid.
- host_release  in  NUM_SLOTS  one-hot or multi-hot pulses freeing full slots.
- mem_we  out  1  write strobe to result memory.
- mem_addr  out  32  word address.
- mem_wdata  out  DATA_W  write data.
- slot_full  out  NUM_SLOTS  bit k=1: slot k holds a completed packet.
- done  out  1  one-cycle pulse: a packet was committed.
- done_slot  out  4  slot index committed; valid with done.
- done_len  out  16  words stored (saturated at SLOT_STRIDE); valid with done.
- truncated  out  1  with done: packet exceeded SLOT_STRIDE words.
- overflow  out  1  one-cycle pulse: packet discarded, no free slot.

Behaviour:
- Reset values:
  - All outputs 0; mem_addr 0; slot_full all 0.
  - State IDLE; wr_ptr 0; word count 0.
- All outputs are registered. A write appears on mem_we/mem_addr/mem_wdata exactly 1 cycle after the accepted beat.
- States: IDLE, WRITE, DISCARD.
- IDLE:
  - pkt_valid&pkt_start with slot_full[wr_ptr]==0: latch base=wr_ptr*SLOT_STRIDE and issue a write of beat 0 at base. If pkt_end is also high, commit immediately (len 1) and stay IDLE; else go to WRITE with count=1.
  - pkt_valid&pkt_start with slot_full[wr_ptr]==1: pulse overflow. If pkt_end is also high, stay IDLE; else go to DISCARD. wr_ptr is unchanged. No search past a full slot; strict in-order allocation.
  - Beats without pkt_start are ignored.
- WRITE:
  - Each pkt_valid beat with count<SLOT_STRIDE writes at base+count, then count++.
  - Beats at count>=SLOT_STRIDE are not written and set the sticky trunc flag.
  - pkt_start inside WRITE is ignored; it is treated as a continuation beat.
  - A pkt_valid&pkt_end beat writes (if room), then commits.
- Commit:
  - Set slot_full[wr_ptr].
  - Pulse done with done_slot=wr_ptr, done_len=min(total beats, SLOT_STRIDE), truncated=trunc. done is registered and aligned with the last mem_we.
  - Advance wr_ptr: wrap NUM_SLOTS-1 -> 0. Clear trunc and count. Return to IDLE.
- DISCARD: no writes; on pkt_valid&pkt_end return to IDLE.
- Release:
  - host_release[k] clears slot_full[k] next cycle, only if it is set.
  - Release of a non-full slot is ignored, including the slot currently being written or committed this cycle.
  - A release in the same cycle as a pkt_start for that slot does not make it free for that start. Occupancy is sampled before the release takes effect.
- mem_addr holds its last value when mem_we=0.
- Reset mid-packet: immediate return to reset values. Any partially written slot is not marked full. Upstream must restart with pkt_start.
- done_len and count are 16 bits; SLOT_STRIDE must be <= 65535.

Test Plan:
- Single 3-word packet after reset: (start,valid,D0),(valid,D1),(valid,end,D2) -> writes addr 0,1,2 with D0..D2 one cycle later; done, done_slot=0, done_len=3, slot_full=5'b00001.
- Five 2-word packets back-to-back -> bases 0, 1550, 3100, 4650, 6200; slot_full=5'b11111; wr_ptr wraps to 0.
- Sixth packet with all slots full -> overflow pulse, zero mem_we, packet consumed to pkt_end, slot_full unchanged. host_release=5'b00001, then next packet -> written at addr 0, done_slot=0.
- SLOT_STRIDE=4 build, 6-word packet -> 4 writes at addr 0..3, done_len=4, truncated=1; next packet starts at addr 4 with truncated=0.
- Single-beat packet (start,valid,end same cycle) with data 0xDEADBEEF -> one write at base, done_len=1, state stays IDLE; a new pkt_start on the very next cycle is accepted into the next slot.
- n_rst asserted after 2 of 4 beats -> all outputs 0, slot_full 0. A following packet is written at addr 0.
